alu_issue_unit: RTL and testbench

- Sits directly upstream of the arithmetic/logic unit.
- Consumes the 16-bit instruction word stream from fetch and assembles complete instructions. Short instructions are 1 word; immediate instructions (bit 3 set) are 3 words / 48 bits.
- Presents ALU-class instructions (inst[2:0]=3'b100) on the ALU's en/inst interface and holds them until done.
- Routes all other classes to a generic valid/ready side port. Counts retired ALU instructions and flags ALU timeouts.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/alu_issue_unit_if.sv | 31 +++
 rtl/inst_assembler.sv | 67 ++++++
 rtl/alu_issue_unit.sv | 127 ++++++++++++
 tb/tb_alu_issue_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU issue path (instruction widths, class codes, issue states).
// Latency: none, declarations only.
// Backpressure: not applicable.
package cpu_pkg;

    localparam int         INST_W    = 48;
    localparam int         WORD_W    = 16;
    localparam int         IMM_BIT   = 3;
    localparam logic [2:0] ALU_CLASS = 3'b100;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        COLLECT,
        ISSUE_ALU,
        ISSUE_OTHER
    } issue_state_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Fetch-word input, ALU en/inst/done and generic side-port bundle of the issue unit.
// Latency: none, wiring only.
// Backpressure: word_ready and oth_ready are the stalls; alu_done releases the ALU hold.
interface alu_issue_if;
    import cpu_pkg::*;

    logic  word_valid;
    word_t word;
    logic  word_ready;

    logic  alu_en;
    inst_t alu_inst;
    logic  alu_done;

    logic  oth_valid;
    inst_t oth_inst;
    logic  oth_ready;

    // Issue-unit side.
    modport master (
        input  word_valid, word, alu_done, oth_ready,
        output word_ready, alu_en, alu_inst, oth_valid, oth_inst
    );

    // Fetch / ALU / side-consumer side.
    modport slave (
        output word_valid, word, alu_done, oth_ready,
        input  word_ready, alu_en, alu_inst, oth_valid, oth_inst
    );

endinterface

// File: rtl/inst_assembler.sv
// Packs 1 or 3 fetch words into a 48-bit instruction; class taken from the first word.
// Latency: complete/inst_nxt are combinational with the accepting word; buffer updates at that edge.
// Backpressure: none of its own, it only advances on accept supplied by the issue FSM.
module inst_assembler
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       accept,
    input  word_t      word,
    output logic [1:0] wcnt,
    output logic       complete,
    output logic       is_alu,
    output inst_t      inst_nxt
);

    logic [1:0] wcnt_q, wcnt_d;
    inst_t      buf_q, buf_d;

    // Next word count and buffer contents; a first word clears the upper 32 bits so short
    // instructions come out zero-extended.
    always_comb begin
        wcnt_d   = wcnt_q;
        buf_d    = buf_q;
        complete = 1'b0;
        if (flush) begin
            wcnt_d = 2'd0;
        end else if (accept) begin
            case (wcnt_q)
                2'd0: begin
                    buf_d = {{(INST_W-WORD_W){1'b0}}, word};
                    if (word[IMM_BIT]) begin
                        wcnt_d = 2'd1;
                    end else begin
                        complete = 1'b1;
                    end
                end
                2'd1: begin
                    buf_d[31:16] = word;
                    wcnt_d       = 2'd2;
                end
                default: begin
                    buf_d[47:32] = word;
                    wcnt_d       = 2'd0;
                    complete     = 1'b1;
                end
            endcase
        end
    end

    // Counter and buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= 2'd0;
            buf_q  <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            buf_q  <= buf_d;
        end
    end

    assign wcnt     = wcnt_q;
    assign inst_nxt = buf_d;
    assign is_alu   = (buf_d[2:0] == ALU_CLASS);

endmodule

// File: rtl/alu_issue_unit.sv
// Assembles fetch words into instructions, holds ALU-class ones on en/inst until done, routes the rest to a valid/ready port.
// Latency: issue starts the cycle after the last word is accepted; a short ALU op occupies 2 cycles with combinational done.
// Backpressure: word_ready drops while an instruction is held or flush is high; oth_valid holds until oth_ready.
module alu_issue_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    alu_issue_if.master      bus,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0]       TIMER_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    issue_state_t     state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             timeout_err_q, timeout_err_d;
    inst_t            alu_inst_q, alu_inst_d;
    inst_t            oth_inst_q, oth_inst_d;

    logic       accept;
    logic [1:0] wcnt;
    logic       complete;
    logic       is_alu;
    inst_t      inst_nxt;

    assign bus.word_ready = (state_q == COLLECT) && !flush;
    assign accept         = bus.word_valid && bus.word_ready;

    inst_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .accept   (accept),
        .word     (bus.word),
        .wcnt     (wcnt),
        .complete (complete),
        .is_alu   (is_alu),
        .inst_nxt (inst_nxt)
    );

    // Issue FSM, ALU watchdog and retire counter; flush overrides done, handshake and timeout.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        retired_d     = retired_q;
        timeout_err_d = 1'b0;
        alu_inst_d    = alu_inst_q;
        oth_inst_d    = oth_inst_q;
        if (flush) begin
            state_d = COLLECT;
            timer_d = 8'd0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (complete) begin
                        timer_d = 8'd0;
                        if (is_alu) begin
                            state_d    = ISSUE_ALU;
                            alu_inst_d = inst_nxt;
                        end else begin
                            state_d    = ISSUE_OTHER;
                            oth_inst_d = inst_nxt;
                        end
                    end
                end
                ISSUE_ALU: begin
                    if (bus.alu_done) begin
                        retired_d = retired_q + CNT_ONE;
                        timer_d   = 8'd0;
                        state_d   = COLLECT;
                    end else if (timer_q == TIMER_LIMIT) begin
                        timeout_err_d = 1'b1;
                        timer_d       = 8'd0;
                        state_d       = COLLECT;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                ISSUE_OTHER: begin
                    if (bus.oth_ready) begin
                        state_d = COLLECT;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // State, timer, counter and held-instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= COLLECT;
            timer_q       <= 8'd0;
            retired_q     <= '0;
            timeout_err_q <= 1'b0;
            alu_inst_q    <= '0;
            oth_inst_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retired_q     <= retired_d;
            timeout_err_q <= timeout_err_d;
            alu_inst_q    <= alu_inst_d;
            oth_inst_q    <= oth_inst_d;
        end
    end

    assign bus.alu_en    = (state_q == ISSUE_ALU);
    assign bus.alu_inst  = alu_inst_q;
    assign bus.oth_valid = (state_q == ISSUE_OTHER);
    assign bus.oth_inst  = oth_inst_q;
    assign busy          = (state_q != COLLECT) || (wcnt != 2'd0);
    assign timeout_err   = timeout_err_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed cases with literal expectations plus random traffic against a queue-based model.
// Latency: model predicts outputs for each cycle, compared on the falling edge.
// Backpressure: oth_ready and alu_done are driven randomly or per directed case.
module tb_alu_issue_unit;
    import cpu_pkg::*;

    localparam int TO = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] retired;

    alu_issue_if bus();

    alu_issue_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: 0 = collecting, 1 = holding an ALU instruction, 2 = holding a side-port instruction.
    int    m_mode;
    word_t m_words[$];
    inst_t m_alu_inst;
    inst_t m_oth_inst;
    int    m_age;
    int    m_retired;
    bit    m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_words.delete();
        m_alu_inst = '0;
        m_oth_inst = '0;
        m_age = 0;
        m_retired = 0;
        m_err = 1'b0;
    endtask

    // Advance the model by the coming rising edge, using the inputs currently applied.
    task automatic model_step();
        bit    e;
        inst_t v;
        e = 1'b0;
        if (flush) begin
            m_mode = 0;
            m_words.delete();
            m_age = 0;
        end else begin
            case (m_mode)
                0: if (bus.word_valid) begin
                    m_words.push_back(bus.word);
                    if (!m_words[0][IMM_BIT] || m_words.size() == 3) begin
                        v = '0;
                        foreach (m_words[i]) v[16*i +: 16] = m_words[i];
                        if (m_words[0][2:0] == ALU_CLASS) begin
                            m_mode = 1;
                            m_alu_inst = v;
                            m_age = 0;
                        end else begin
                            m_mode = 2;
                            m_oth_inst = v;
                        end
                        m_words.delete();
                    end
                end
                1: if (bus.alu_done) begin
                    m_retired = (m_retired + 1) % (1 << CW);
                    m_mode = 0;
                end else if (m_age == TO - 1) begin
                    e = 1'b1;
                    m_mode = 0;
                end else begin
                    m_age++;
                end
                default: if (bus.oth_ready) m_mode = 0;
            endcase
        end
        m_err = e;
    endtask

    // Compare every output against the model each cycle, then advance the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("word_ready",  64'(bus.word_ready), 64'(m_mode == 0 && !flush));
            chk("alu_en",      64'(bus.alu_en),     64'(m_mode == 1));
            chk("oth_valid",   64'(bus.oth_valid),  64'(m_mode == 2));
            chk("alu_inst",    64'(bus.alu_inst),   64'(m_alu_inst));
            chk("oth_inst",    64'(bus.oth_inst),   64'(m_oth_inst));
            chk("busy",        64'(busy),           64'(m_mode != 0 || m_words.size() != 0));
            chk("timeout_err", 64'(timeout_err),    64'(m_err));
            chk("retired",     64'(retired),        64'(m_retired));
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input word_t w);
        bus.word_valid = 1'b1;
        bus.word = w;
        tick();
        bus.word_valid = 1'b0;
    endtask

    int n_en;
    int n_to;
    int need;

    initial begin
        bus.word_valid = 1'b0;
        bus.word = '0;
        bus.alu_done = 1'b0;
        bus.oth_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_word_ready", 64'(bus.word_ready), 64'd1);
        chk("rst_alu_en",     64'(bus.alu_en),     64'd0);
        chk("rst_oth_valid",  64'(bus.oth_valid),  64'd0);
        chk("rst_busy",       64'(busy),           64'd0);
        chk("rst_retired",    64'(retired),        64'd0);
        chk("rst_alu_inst",   64'(bus.alu_inst),   64'd0);

        // Short ALU op with same-cycle done.
        bus.alu_done = 1'b1;
        feed(16'h1284);
        #1;
        chk("short_alu_en",     64'(bus.alu_en),     64'd1);
        chk("short_alu_inst",   64'(bus.alu_inst),   64'h0000_0000_1284);
        chk("short_word_ready", 64'(bus.word_ready), 64'd0);
        tick();
        #1;
        chk("short_alu_en_off", 64'(bus.alu_en), 64'd0);
        chk("short_retired",    64'(retired),    64'd1);

        // Immediate ALU op, done on the 4th issue cycle.
        bus.alu_done = 1'b0;
        feed(16'h008C);
        feed(16'hBEEF);
        feed(16'hDEAD);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.alu_done = 1'b1;
            #1;
            chk("imm_alu_en",   64'(bus.alu_en),   64'd1);
            chk("imm_alu_inst", 64'(bus.alu_inst), 64'hDEAD_BEEF_008C);
            tick();
        end
        bus.alu_done = 1'b0;
        #1;
        chk("imm_retired", 64'(retired), 64'd2);

        // Side-port instruction stalled for five cycles.
        feed(16'h0001);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("oth_valid_held", 64'(bus.oth_valid),  64'd1);
            chk("oth_inst_held",  64'(bus.oth_inst),   64'h0000_0000_0001);
            chk("oth_no_alu_en",  64'(bus.alu_en),     64'd0);
            chk("oth_word_ready", 64'(bus.word_ready), 64'd0);
            tick();
        end
        bus.oth_ready = 1'b1;
        tick();
        bus.oth_ready = 1'b0;
        #1;
        chk("oth_released", 64'(bus.oth_valid), 64'd0);

        // ALU watchdog: done never arrives.
        feed(16'h1284);
        n_en = 0;
        n_to = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            n_en += int'(bus.alu_en);
            n_to += int'(timeout_err);
            tick();
        end
        chk("timeout_en_cycles", 64'(n_en),    64'd16);
        chk("timeout_pulses",    64'(n_to),    64'd1);
        chk("timeout_retired",   64'(retired), 64'd2);

        // Flush mid-assembly, then flush while done is high.
        feed(16'h008C);
        feed(16'hBEEF);
        flush = 1'b1;
        bus.word_valid = 1'b1;
        bus.word = 16'hDEAD;
        #1;
        chk("flush_word_ready", 64'(bus.word_ready), 64'd0);
        tick();
        flush = 1'b0;
        bus.word_valid = 1'b0;
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        feed(16'h1284);
        #1;
        chk("flush_fresh_en",   64'(bus.alu_en),   64'd1);
        chk("flush_fresh_inst", 64'(bus.alu_inst), 64'h0000_0000_1284);
        flush = 1'b1;
        bus.alu_done = 1'b1;
        tick();
        flush = 1'b0;
        bus.alu_done = 1'b0;
        #1;
        chk("flush_no_retire", 64'(retired),    64'd2);
        chk("flush_alu_off",   64'(bus.alu_en), 64'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bus.word_valid = ($urandom_range(0, 3) != 0);
            bus.word = 16'($urandom);
            if ($urandom_range(0, 1) == 1) bus.word[2:0] = ALU_CLASS;
            bus.alu_done = ($urandom_range(0, 5) == 0);
            bus.oth_ready = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 40) == 0);
            tick();
        end

        // Drive retired up to its wrap point.
        bus.word_valid = 1'b0;
        flush = 1'b0;
        bus.alu_done = 1'b1;
        bus.oth_ready = 1'b1;
        repeat (3) tick();
        need = (1 << CW) - m_retired;
        for (int k = 0; k < need; k++) begin
            feed(16'h1284);
            tick();
        end
        #1;
        chk("retired_wrap", 64'(retired), 64'd0);

        // Asynchronous reset while an ALU instruction is held.
        bus.alu_done = 1'b0;
        bus.oth_ready = 1'b0;
        feed(16'h1284);
        #1;
        chk("pre_rst_alu_en", 64'(bus.alu_en), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_alu_en",  64'(bus.alu_en), 64'd0);
        chk("async_rst_retired", 64'(retired),    64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("post_rst_word_ready", 64'(bus.word_ready), 64'd1);
        chk("post_rst_busy",       64'(busy),           64'd0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
